palette_lookup: RTL and testbench
=================================

# palette_lookup

Pixel-pipeline stage that sits directly downstream of the 256×16 palette RAM. It takes the composer's 8-bit colour-index stream and drives the RAM read port. It formats the returned 12-bit 0xRGB words into a registered 4:4:4 RGB output, with sync/blank sideband delayed to match. There is no backpressure: one pixel per enabled clock, fixed latency.

## Interface
Parameters:
- LATENCY, 3, input-to-output delay in enabled clocks; fixed, not user-tunable, exported for downstream alignment.

Ports:
- clk_i  in  1  video clock; also drives palette RAM rd_clk_i.
- rst_n_i  in  1  reset; **one clock; reset is synchronous and active-low**.
- pix_en_i  in  1  clock enable; pipeline advances only when high.
- pix_valid_i  in  1  index on pix_index_i is an active-area pixel.
- pix_index_i  in  8  palette index.
- border_i  in  1  pixel is border; substitute border_idx_i.
- border_idx_i  in  8  border colour index (quasi-static register).
- blank_i, hsync_i, vsync_i  in  1 each  sideband.
- chroma_kill_i  in  1  monochrome request (used only with macro).
- rd_en_o  out  1  palette RAM read enable.
- rd_addr_o  out  8  palette RAM read address.
- rd_data_i  in  16  palette RAM data; registered inside RAM, valid 1 clock after address.
- r_o, g_o, b_o  out  4 each  colour.
- blank_o, hsync_o, vsync_o  out  1 each  delayed sideband.
- valid_o  out  1  delayed pix_valid_i.

## Operation
- Stage A (register on enabled edge): address select. If border_i, then border_idx_i; else if pix_valid_i, then pix_index_i; else 0x00. rd_en_o = pix_en_i & ~blank (stage-A copy). Sideband captured.
- Stage B: RAM read in flight; sideband shifted.
- Stage C (output register): r = rd_data_i[11:8], g = [7:4], b = [3:0]. Bits [15:12] are ignored. If stage-C blank, RGB is forced to 0x000 regardless of data.
- Border takes priority over pix_valid_i. Blank takes priority over both, at the output.
- pix_en_i low: all stage registers and outputs hold. rd_en_o is low, so the RAM output also holds. Pipeline stays coherent across gaps of any length.
- Palette writes to the address currently being read follow RAM read-during-write behaviour. This block does not arbitrate.

## Timing
- Index sampled at enabled edge N; rd_addr_o valid after N; RGB/sideband/valid_o valid after enabled edge N+2, i.e. LATENCY = 3 enabled clocks including the input register.
- Sideband and valid_o delay equals RGB delay exactly, including under pix_en_i gating.
- Reset (rst_n_i low at an edge): all registers clear. rd_addr_o=0x00, rd_en_o=0, r/g/b=0, blank_o=1, hsync_o=0, vsync_o=0, valid_o=0.
- Reset mid-frame: in-flight pixels are discarded; the first post-reset pixel emerges after a full LATENCY. The output shows blank (blank_o=1, RGB 0) until then.
- border_idx_i/chroma_kill_i sampled at stage A / stage C respectively; a change takes effect on the next pixel through that stage.

## Configuration
- PALETTE_CHROMA_KILL_EN defined: when chroma_kill_i=1 at stage C, output r=g=b=Y with Y = (5·R + 9·G + 2·B) >> 4. Intermediate width is 8 bits, max 240, so Y ≤ 15 with no saturation needed. Blank forcing still applies after the conversion.
- Not defined: chroma_kill_i is ignored (port kept, unconnected internally); RGB is always the direct palette nibbles.

## Structure
- palette_pkg: LATENCY constant; luma weights (5, 9, 2) and shift (4); rgb444 struct typedef (r, g, b nibbles); reset values for sideband.
- One sub-module, palette_luma: combinational RGB444→Y, instantiated only under PALETTE_CHROMA_KILL_EN.

## Test plan
- Reset then stream indices 1, 2, 3 with pix_en_i=1 (RAM defaults 0xFFF, 0x800, 0xAFE) -> RGB FFF, 800, AFE on clocks 3, 4, 5; valid_o aligned.
- border_i=1, border_idx_i=0x0E, pix_index_i=0x01 -> rd_addr_o=0x0E, output 0x08F; blank_i=1 with index 1 -> output 000, rd_en_o=0.
- pix_en_i toggled 1,0,0,1,… over an index ramp 0..15 -> output sequence identical to ungated run; hsync_o/vsync_o stay aligned with pixels.
- Assert rst_n_i for one clock with 3 pixels in flight -> outputs reset values next clock; no stale pixel emerges.
- With PALETTE_CHROMA_KILL_EN and chroma_kill_i=1: index 2 (0x800) -> 0x222; index 1 (0xFFF) -> 0xFFF; index 5 (0x0C5) -> Y=(0+108+10)>>4=7 -> 0x777. Without the macro, index 2 -> 0x800.
- Write palette entry 0x10 = 0x123 via RAM port, then read index 0x10 -> 0x123; ben=2'b10 write of 0xAB00 -> 0xB23 (upper nibble ignored).

Source files
------------

// File: rtl/palette_pkg.sv
// palette_pkg: shared constants and types for the palette lookup stage.
// Optional feature macro used by this slice: PALETTE_CHROMA_KILL_EN.
package palette_pkg;

  // Input register + RAM read + output register.
  localparam int PIPE_LATENCY = 3;

  // BT.601-ish integer luma weights; they sum to 16 so the shift normalises.
  localparam logic [7:0] LUMA_W_R   = 8'd5;
  localparam logic [7:0] LUMA_W_G   = 8'd9;
  localparam logic [7:0] LUMA_W_B   = 8'd2;
  localparam int         LUMA_SHIFT = 4;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef struct packed {
    logic blank;
    logic hsync;
    logic vsync;
    logic valid;
  } sideband_t;

  // Reset shows a blanked, sync-inactive, invalid pixel.
  localparam sideband_t SIDEBAND_RST = '{blank: 1'b1, hsync: 1'b0, vsync: 1'b0, valid: 1'b0};

endpackage

// File: rtl/palette_luma.sv
// palette_luma: combinational RGB444 to 4-bit luma.
// Only instantiated when PALETTE_CHROMA_KILL_EN is defined.
module palette_luma
  import palette_pkg::*;
(
  input  rgb444_t    rgb,
  output logic [3:0] y
);

  logic [7:0] sum;

  // Weighted sum peaks at 240, so 8 bits never overflow and y never saturates.
  always_comb begin
    sum = LUMA_W_R * {4'h0, rgb.r} + LUMA_W_G * {4'h0, rgb.g} + LUMA_W_B * {4'h0, rgb.b};
    y   = sum[LUMA_SHIFT +: 4];
  end

endmodule

// File: rtl/palette_lookup.sv
// palette_lookup: colour-index to RGB444 stage in front of the palette RAM.
// Three enabled clocks of latency; sideband is delayed to match exactly.
// Optional monochrome output under macro PALETTE_CHROMA_KILL_EN.
module palette_lookup
  import palette_pkg::*;
#(
  parameter int LATENCY = PIPE_LATENCY
)
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        pix_en_i,
  input  logic        pix_valid_i,
  input  logic [7:0]  pix_index_i,
  input  logic        border_i,
  input  logic [7:0]  border_idx_i,
  input  logic        blank_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        chroma_kill_i,
  output logic        rd_en_o,
  output logic [7:0]  rd_addr_o,
  input  logic [15:0] rd_data_i,
  output logic [3:0]  r_o,
  output logic [3:0]  g_o,
  output logic [3:0]  b_o,
  output logic        blank_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        valid_o
);

  logic [7:0] addr_a;
  sideband_t  sb_in;
  sideband_t  sb_pipe [LATENCY];
  rgb444_t    rgb_raw;
  rgb444_t    rgb_fmt;
  rgb444_t    rgb_c;
  logic       unused_bits;

  // Bundle incoming sideband so it travels as one word.
  always_comb begin
    sb_in = '{blank: blank_i, hsync: hsync_i, vsync: vsync_i, valid: pix_valid_i};
  end

  // Stage A: pick the RAM address; border wins over an active pixel.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      addr_a <= 8'h00;
    end else if (pix_en_i) begin
      if (border_i)         addr_a <= border_idx_i;
      else if (pix_valid_i) addr_a <= pix_index_i;
      else                  addr_a <= 8'h00;
    end
  end

  // Sideband delay line, one entry per pipeline stage (A, B, C).
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < LATENCY; i++) sb_pipe[i] <= SIDEBAND_RST;
    end else if (pix_en_i) begin
      sb_pipe[0] <= sb_in;
      for (int i = 1; i < LATENCY; i++) sb_pipe[i] <= sb_pipe[i-1];
    end
  end

  // Reads only on enabled clocks so the RAM output holds across gaps.
  assign rd_en_o   = pix_en_i & ~sb_pipe[0].blank;
  assign rd_addr_o = addr_a;

  // Palette word is 0xRGB in the low 12 bits; the top nibble is don't-care.
  always_comb begin
    rgb_raw = '{r: rd_data_i[11:8], g: rd_data_i[7:4], b: rd_data_i[3:0]};
  end

`ifdef PALETTE_CHROMA_KILL_EN
  logic [3:0] luma;

  palette_luma u_luma (
    .rgb (rgb_raw),
    .y   (luma)
  );

  // Monochrome substitution, sampled together with the output register.
  always_comb begin
    rgb_fmt = chroma_kill_i ? '{r: luma, g: luma, b: luma} : rgb_raw;
  end

  assign unused_bits = ^rd_data_i[15:12];
`else
  // Direct palette nibbles; the kill request has no effect in this build.
  always_comb begin
    rgb_fmt = rgb_raw;
  end

  assign unused_bits = ^{rd_data_i[15:12], chroma_kill_i};
`endif

  // Stage C: output register, blank forces black after any conversion.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rgb_c <= '0;
    end else if (pix_en_i) begin
      rgb_c <= sb_pipe[LATENCY-2].blank ? '0 : rgb_fmt;
    end
  end

  assign r_o     = rgb_c.r;
  assign g_o     = rgb_c.g;
  assign b_o     = rgb_c.b;
  assign blank_o = sb_pipe[LATENCY-1].blank;
  assign hsync_o = sb_pipe[LATENCY-1].hsync;
  assign vsync_o = sb_pipe[LATENCY-1].vsync;
  assign valid_o = sb_pipe[LATENCY-1].valid;

endmodule

// File: tb/tb_palette_lookup.sv
// tb_palette_lookup: scoreboard bench for palette_lookup with a behavioural
// registered-read palette RAM. Honours PALETTE_CHROMA_KILL_EN if defined.
module tb_palette_lookup;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        pix_en_i;
  logic        pix_valid_i;
  logic [7:0]  pix_index_i;
  logic        border_i;
  logic [7:0]  border_idx_i;
  logic        blank_i;
  logic        hsync_i;
  logic        vsync_i;
  logic        chroma_kill_i;
  logic        rd_en_o;
  logic [7:0]  rd_addr_o;
  logic [15:0] rd_data_i;
  logic [3:0]  r_o, g_o, b_o;
  logic        blank_o, hsync_o, vsync_o, valid_o;

  logic [15:0] mem [256];
  logic [15:0] q [$];
  logic [15:0] last_exp;
  logic [15:0] out_word;
  int          checks = 0;
  int          errors = 0;

  localparam logic [15:0] RESET_EXP = 16'h8000;

  palette_lookup dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .pix_en_i      (pix_en_i),
    .pix_valid_i   (pix_valid_i),
    .pix_index_i   (pix_index_i),
    .border_i      (border_i),
    .border_idx_i  (border_idx_i),
    .blank_i       (blank_i),
    .hsync_i       (hsync_i),
    .vsync_i       (vsync_i),
    .chroma_kill_i (chroma_kill_i),
    .rd_en_o       (rd_en_o),
    .rd_addr_o     (rd_addr_o),
    .rd_data_i     (rd_data_i),
    .r_o           (r_o),
    .g_o           (g_o),
    .b_o           (b_o),
    .blank_o       (blank_o),
    .hsync_o       (hsync_o),
    .vsync_o       (vsync_o),
    .valid_o       (valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Palette RAM: registered read, data valid one clock after the address.
  always @(posedge clk_i) begin
    if (rd_en_o) rd_data_i <= mem[rd_addr_o];
  end

  assign out_word = {blank_o, hsync_o, vsync_o, valid_o, r_o, g_o, b_o};

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] fmt(input logic [11:0] d);
    logic [11:0] res;
    res = d;
`ifdef PALETTE_CHROMA_KILL_EN
    if (chroma_kill_i) begin
      int y;
      y = (5 * int'(d[11:8]) + 9 * int'(d[7:4]) + 2 * int'(d[3:0])) >> 4;
      res = {y[3:0], y[3:0], y[3:0]};
    end
`endif
    return res;
  endfunction

  task automatic ram_write(input logic [7:0] a, input logic [15:0] d, input logic [1:0] ben);
    if (ben[0]) mem[a][7:0]  = d[7:0];
    if (ben[1]) mem[a][15:8] = d[15:8];
  endtask

  task automatic restart_sb();
    q.delete();
    q.push_back(RESET_EXP);
    q.push_back(RESET_EXP);
    last_exp = RESET_EXP;
  endtask

  // One clock of stimulus; enabled clocks push an expectation and pop the
  // one that is due, disabled clocks check that everything holds.
  task automatic drive(input logic en, input logic val, input logic [7:0] idx,
                       input logic brd, input logic blk, input logic hs, input logic vs);
    logic [7:0]  a;
    logic [15:0] e;
    pix_en_i    = en;
    pix_valid_i = val;
    pix_index_i = idx;
    border_i    = brd;
    blank_i     = blk;
    hsync_i     = hs;
    vsync_i     = vs;
    @(posedge clk_i);
    #1;
    if (en) begin
      a = brd ? border_idx_i : (val ? idx : 8'h00);
      chk("rd_addr", {8'h00, rd_addr_o}, {8'h00, a});
      chk("rd_en", {15'h0, rd_en_o}, {15'h0, ~blk});
      e = blk ? {1'b1, hs, vs, val, 12'h000} : {1'b0, hs, vs, val, fmt(mem[a][11:0])};
      q.push_back(e);
      if (q.size() >= 3) begin
        last_exp = q.pop_front();
        chk("pixel", out_word, last_exp);
      end
    end else begin
      chk("hold", out_word, last_exp);
      chk("rd_en_idle", {15'h0, rd_en_o}, 16'h0000);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic pat [4];
    int   n;
    int   k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0137) ^ 16'h3000;
    mem[1]    = 16'h0FFF;
    mem[2]    = 16'h0800;
    mem[3]    = 16'h5AFE;
    mem[5]    = 16'h00C5;
    mem[8'h0E] = 16'hE08F;
    rd_data_i = 16'h0000;

    rst_n_i = 1'b0;  pix_en_i = 1'b1; pix_valid_i = 1'b1; pix_index_i = 8'h33;
    border_i = 1'b0; border_idx_i = 8'h0E; blank_i = 1'b0;
    hsync_i = 1'b1;  vsync_i = 1'b1; chroma_kill_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_out", out_word, RESET_EXP);
    chk("rst_addr", {8'h00, rd_addr_o}, 16'h0000);
    chk("rst_rden", {15'h0, rd_en_o}, 16'h0000);
    rst_n_i = 1'b1;
    restart_sb();

    // Basic stream: 1, 2, 3 -> FFF, 800, AFE
    drive(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("first_rgb", {4'h0, r_o, g_o, b_o}, 16'h0FFF);
    flush();

    // Border priority and blank forcing
    drive(1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("border_rgb", {4'h0, r_o, g_o, b_o}, 16'h008F);
    flush();

    // Gated ramp 0..15
    n = 0;
    k = 0;
    while (n < 16) begin
      if (pat[k % 4]) begin
        drive(1'b1, 1'b1, 8'(n), 1'b0, (n == 12), (n % 5 == 0), (n == 7));
        n++;
      end else begin
        drive(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
      end
      k++;
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // Reset with three pixels in flight
    drive(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1);
    rst_n_i = 1'b0;
    pix_en_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("midrst_out", out_word, RESET_EXP);
    chk("midrst_addr", {8'h00, rd_addr_o}, 16'h0000);
    chk("midrst_rden", {15'h0, rd_en_o}, 16'h0000);
    rst_n_i = 1'b1;
    restart_sb();
    drive(1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    flush();

    // RAM writes, including a byte-lane write that touches the ignored nibble
    ram_write(8'h10, 16'h0123, 2'b11);
    drive(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    flush();
    ram_write(8'h10, 16'hAB00, 2'b10);
    drive(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ben_rgb", {4'h0, r_o, g_o, b_o}, 16'h0B23);
    flush();

    // Chroma kill request: monochrome only when the feature is built in
    chroma_kill_i = 1'b1;
    drive(1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PALETTE_CHROMA_KILL_EN
    chk("kill_rgb", {4'h0, r_o, g_o, b_o}, 16'h0222);
`else
    chk("kill_rgb", {4'h0, r_o, g_o, b_o}, 16'h0800);
`endif
    flush();
    chroma_kill_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
